// File: rtl/nibb_hex_tx_if.sv
// Byte-wide valid/ready channel from the hex formatter to the UART transmitter.
//   tx_data  : ASCII character (master -> slave)
//   tx_valid : tx_data is valid (master -> slave)
//   tx_ready : transmitter can take a byte (slave -> master)
// A byte transfers on any cycle where tx_valid && tx_ready.
interface nibb_hex_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/nibb_hex_tx.sv
// Formats a captured word as uppercase ASCII hex, most-significant nibble first,
// optionally followed by CR/LF, and streams it over a valid/ready byte channel.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   start   : request to send data_in; honoured only when idle
//   data_in : word to format, sampled on the accepted start cycle
//   busy    : high whenever a frame is in progress (including the done cycle)
//   done    : one-cycle pulse after the final character has transferred
//   tx      : byte channel to the UART transmitter (master side)
module nibb_hex_tx #(
  parameter int unsigned NIBBLES     = 4,
  parameter int unsigned APPEND_CRLF = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   data_in,
  output logic                   busy,
  output logic                   done,
  nibb_hex_tx_if.master          tx
);

  localparam int unsigned Width   = 4 * NIBBLES;
  // Three bits cover the largest legal nibble index (7).
  localparam logic [2:0]  CntInit = 3'(NIBBLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHex,
    StCr,
    StLf,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [Width-1:0]   shift_q, shift_d;
  logic [2:0]         cnt_q, cnt_d;

  function automatic logic [7:0] to_ascii(input logic [3:0] nib);
    if (nib < 4'hA) begin
      to_ascii = 8'h30 + {4'h0, nib};
    end else begin
      to_ascii = 8'h37 + {4'h0, nib};
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // tx_valid is constant within HEX/CR/LF, so a transfer is just tx_ready there.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StHex;
          shift_d = data_in;
          cnt_d   = CntInit;
        end
      end
      StHex: begin
        if (tx.tx_ready) begin
          if (cnt_q != 3'd0) begin
            shift_d = shift_q << 4;
            cnt_d   = cnt_q - 3'd1;
          end else if (APPEND_CRLF != 0) begin
            state_d = StCr;
          end else begin
            state_d = StDone;
          end
        end
      end
      StCr: begin
        if (tx.tx_ready) state_d = StLf;
      end
      StLf: begin
        if (tx.tx_ready) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode registered state only; no path from tx_ready.
  always_comb begin
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    busy        = (state_q != StIdle);
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
      end
      StHex: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = to_ascii(shift_q[Width-1 -: 4]);
      end
      StCr: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = 8'h0D;
      end
      StLf: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = 8'h0A;
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_nibb_hex_tx.sv
// Bench for nibb_hex_tx: three instances (defaults, no CR/LF, two nibbles)
// share start/data/ready; sel picks which instance is exercised and observed.
module tb_nibb_hex_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic        tx_ready;
  int          sel;

  int n_cmp = 0;
  int n_err = 0;

  byte unsigned exp_q[$];

  always #5 clk = ~clk;

  nibb_hex_tx_if if_a ();
  nibb_hex_tx_if if_b ();
  nibb_hex_tx_if if_c ();
  assign if_a.tx_ready = tx_ready;
  assign if_b.tx_ready = tx_ready;
  assign if_c.tx_ready = tx_ready;

  logic busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic start_a, start_b, start_c;
  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);

  nibb_hex_tx #(.NIBBLES(4), .APPEND_CRLF(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .data_in(data_in),
    .busy(busy_a), .done(done_a), .tx(if_a.master)
  );
  nibb_hex_tx #(.NIBBLES(4), .APPEND_CRLF(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .data_in(data_in),
    .busy(busy_b), .done(done_b), .tx(if_b.master)
  );
  nibb_hex_tx #(.NIBBLES(2), .APPEND_CRLF(1)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .data_in(data_in[7:0]),
    .busy(busy_c), .done(done_c), .tx(if_c.master)
  );

  logic       o_busy, o_done, o_valid;
  logic [7:0] o_data;
  always_comb begin
    o_busy  = busy_a;
    o_done  = done_a;
    o_valid = if_a.tx_valid;
    o_data  = if_a.tx_data;
    if (sel == 1) begin
      o_busy  = busy_b;
      o_done  = done_b;
      o_valid = if_b.tx_valid;
      o_data  = if_b.tx_data;
    end else if (sel == 2) begin
      o_busy  = busy_c;
      o_done  = done_c;
      o_valid = if_c.tx_valid;
      o_data  = if_c.tx_data;
    end
  end

  // Reference: the expected character stream of one frame.
  function automatic void build_exp(input logic [15:0] w, input int nib, input int crlf);
    string hexs = "0123456789ABCDEF";
    exp_q.delete();
    for (int i = nib - 1; i >= 0; i--) begin
      exp_q.push_back(hexs[int'((w >> (4 * i)) & 16'hF)]);
    end
    if (crlf != 0) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0 repeating; 2: random ready.
  // spurious: pulse start with 0x9999 mid-frame and in the done cycle.
  task automatic run_frame(input int s, input logic [15:0] word, input int mode,
                           input bit spurious);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    sel = s;
    build_exp(word, (s == 2) ? 2 : 4, (s == 1) ? 0 : 1);
    data_in  = word;
    start    = 1'b1;
    tx_ready = 1'b0;
    step();
    start   = 1'b0;
    data_in = 16'($urandom);
    while (idx < exp_q.size() && cyc < 300) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tx_ready = rdy;
      if (spurious && cyc == 1) begin
        start   = 1'b1;
        data_in = 16'h9999;
      end else begin
        start = 1'b0;
      end
      n_cmp++;
      if (o_valid !== 1'b1 || o_data !== exp_q[idx] || o_busy !== 1'b1 || o_done !== 1'b0) begin
        n_err++;
        $display("FAIL char[%0d] sel=%0d: valid=%b data=%h busy=%b done=%b, required 1 %h 1 0",
                 idx, s, o_valid, o_data, o_busy, o_done, exp_q[idx]);
      end
      if (rdy) idx++;
      cyc++;
      step();
    end
    n_cmp++;
    if (idx != exp_q.size()) begin
      n_err++;
      $display("FAIL frame_budget sel=%0d: sent %0d chars, required %0d", s, idx, exp_q.size());
    end
    tx_ready = 1'($urandom_range(0, 1));
    if (spurious) begin
      start   = 1'b1;
      data_in = 16'h9999;
    end
    n_cmp++;
    if (o_done !== 1'b1 || o_busy !== 1'b1 || o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL done_cycle sel=%0d: done=%b busy=%b valid=%b, required 1 1 0",
               s, o_done, o_busy, o_valid);
    end
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
        n_err++;
        $display("FAIL idle_after[%0d] sel=%0d: done=%b busy=%b valid=%b, required 0 0 0",
                 k, s, o_done, o_busy, o_valid);
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; data_in = 16'h0; tx_ready = 1'b0; sel = 0;
    step();
    step();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_cmp++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_valid !== 1'b0 || o_data !== 8'h00) begin
        n_err++;
        $display("FAIL reset sel=%0d: busy=%b done=%b valid=%b data=%h, required 0 0 0 00",
                 s, o_busy, o_done, o_valid, o_data);
      end
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_default();
    run_frame(0, 16'h1A2F, 0, 1'b0);
  endtask

  task automatic test_no_crlf();
    run_frame(1, 16'h0000, 0, 1'b0);
    run_frame(1, 16'hFFFF, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_frame(0, 16'hBEEF, 1, 1'b0);
  endtask

  task automatic test_ignore_start();
    run_frame(0, 16'h1234, 0, 1'b1);
  endtask

  task automatic test_mid_reset();
    sel = 0;
    build_exp(16'h1234, 4, 1);
    data_in = 16'h1234; start = 1'b1; tx_ready = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== exp_q[0]) begin
      n_err++;
      $display("FAIL rst_char0: valid=%b data=%h, required 1 %h", o_valid, o_data, exp_q[0]);
    end
    step();
    tx_ready = 1'b0;
    rst      = 1'b1;
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== exp_q[1]) begin
      n_err++;
      $display("FAIL rst_char1: valid=%b data=%h, required 1 %h", o_valid, o_data, exp_q[1]);
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
        n_err++;
        $display("FAIL rst_abort[%0d]: valid=%b busy=%b done=%b, required 0 0 0",
                 k, o_valid, o_busy, o_done);
      end
      tx_ready = 1'($urandom_range(0, 1));
      step();
    end
    run_frame(0, 16'h00C3, 0, 1'b0);
  endtask

  task automatic test_two_nibbles();
    run_frame(2, 16'h007E, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_frame(i % 3, 16'($urandom), 2, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_no_crlf();
    test_backpressure();
    test_ignore_start();
    test_mid_reset();
    test_two_nibbles();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
